syn_fifo_fwft: RTL and testbench
================================

// Module: syn_fifo_fwft
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the syn_fifo buffer.
//  Adds selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty
//  thresholds, occupancy count, sticky overflow/underflow flags, synchronous flush and non-power-of-2 depth.
//  Sits between a producer and a consumer in the same clock domain, e.g. core-to-peripheral data staging.
// PARAMETERS
//  FIFO_ENTRIES   16   storage depth, >=2, any integer (need not be a power of 2)
//  DATA_WIDTH     8    bits per entry
//  FWFT           0    0 = standard registered read; 1 = first-word-fall-through
//  AFULL_THRESH   14   almost_full asserts when count >= AFULL_THRESH
//  AEMPTY_THRESH  2    almost_empty asserts when count <= AEMPTY_THRESH
//  IW = $clog2(FIFO_ENTRIES); CW = $clog2(FIFO_ENTRIES+1)
// PORTS
//  sys_clk       in   1    single clock; all state changes on rising edge
//  sys_rst       in   1    asynchronous reset, active-high
//  flush         in   1    synchronous clear of pointers/count/flags
//  wr_en         in   1    write request
//  wr_data       in   DW   write data
//  wr_index      out  IW   slot targeted by the next write (write pointer)
//  rd_en         in   1    read request (FWFT: pop of the head word)
//  rd_data       out  DW   read data
//  rd_valid      out  1    rd_data qualifier
//  rd_index      out  IW   slot targeted by the next read (read pointer)
//  full          out  1    count == FIFO_ENTRIES
//  empty         out  1    count == 0
//  almost_full   out  1    count >= AFULL_THRESH
//  almost_empty  out  1    count <= AEMPTY_THRESH
//  count         out  CW   current occupancy
//  overflow      out  1    sticky: write attempted while full
//  underflow     out  1    sticky: read attempted while empty
// BEHAVIOUR
//  Reset (async, immediate): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0,
//   empty=1, almost_empty=1, full=0, almost_full=0. Memory array is not reset.
//  Acceptance: wr_acc = wr_en & ~full & ~flush; rd_acc = rd_en & ~empty & ~flush.
//   Flags use registered count only, so a write while full is rejected even if a read is accepted
//   in the same cycle.
//  Write: on wr_acc, mem[wr_ptr] <= wr_data. wr_ptr advances; it wraps FIFO_ENTRIES-1 -> 0.
//  Read pointer: advances on rd_acc with the same wrap rule.
//  Count: count <= count + wr_acc - rd_acc.
//   - Both accepted: count and flags are unchanged and both pointers advance.
//  Flag timing: full, empty, almost_* are combinational decodes of registered count.
//   They are valid in the cycle after the access.
//  Standard mode (FWFT=0):
//   - rd_acc: rd_data <= mem[rd_ptr] and rd_valid <= 1, so data arrives 1 cycle after rd_en.
//   - No rd_acc: rd_valid <= 0 and rd_data holds its last value.
//  FWFT mode (FWFT=1):
//   - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
//   - A word written at edge N is visible after edge N, with no rd_en needed.
//   - rd_en pops the head word.
//  Errors: wr_en & full sets overflow; rd_en & empty sets underflow.
//   - The rejected operation changes no state.
//   - Flags clear only on sys_rst or flush.
//  Flush: pointers=0, count=0, rd_valid=0, overflow=underflow=0 at the next edge.
//   - Concurrent wr_en/rd_en are ignored and do not set error flags.
//  Reset mid-operation: an in-flight write is discarded and the FIFO is empty after reset deasserts.
// TESTING (FIFO_ENTRIES=16, DATA_WIDTH=8 unless noted)
//  1. Write 16 random words from reset.
//     -> wr_index steps 0..15; almost_full=1 once count=14; full=1, count=16.
//     -> A 17th write sets overflow=1; mem and count are unchanged.
//  2. FWFT=0, drain 16 reads after test 1.
//     -> Words come out in write order, each with rd_valid one cycle after rd_en; empty=1 at end.
//     -> A 17th read sets underflow=1; rd_data holds the last word.
//  3. Preload 5 words, then run 48 cycles with wr_en=rd_en=1.
//     -> count stays 5 with no flag toggles; pointers wrap 3 times; output order matches input.
//  4. FWFT=1, write 0xA5 at edge N with rd_en=0.
//     -> After edge N: rd_valid=1, rd_data=0xA5, empty=0.
//     -> rd_en for 1 cycle gives rd_valid=0, empty=1.
//  5. Fill to count=9 with overflow set, pulse flush.
//     -> Next cycle: count=0, empty=1, overflow=0, wr_index=rd_index=0.
//     -> Repeat with sys_rst mid-burst: same result, asynchronously.
//  6. FIFO_ENTRIES=12, 30 single write/read pairs.
//     -> Indices wrap 11 -> 0 and never reach 12; data order is preserved.

Source files
------------

// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky error flags and flush.
module syn_fifo_fwft #(
    parameter int FIFO_ENTRIES  = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    localparam int IW = $clog2(FIFO_ENTRIES),
    localparam int CW = $clog2(FIFO_ENTRIES + 1)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [IW-1:0]         wr_index,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [IW-1:0]         rd_index,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [IW-1:0] LAST_IDX  = IW'(FIFO_ENTRIES - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_ENTRIES);
    localparam logic [CW-1:0] AF_CNT    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_CNT    = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_ENTRIES];
    logic [IW-1:0]         wr_ptr;
    logic [IW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IW'(1);
    endfunction

    assign full         = (occ == DEPTH_CNT);
    assign empty        = (occ == '0);
    assign almost_full  = (occ >= AF_CNT);
    assign almost_empty = (occ <= AE_CNT);
    assign count        = occ;
    assign wr_index     = wr_ptr;
    assign rd_index     = rd_ptr;

    // Acceptance uses the registered count only: a write while full is refused
    // even when a read is accepted in the same cycle.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            // Registered read: rd_data keeps the last popped word when idle.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (rd_acc) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// Directed bench for syn_fifo_fwft: standard 16-deep, FWFT 16-deep and
// standard 12-deep instances share one clock and reset.
module tb_syn_fifo_fwft;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: standard read, 16 entries
    logic       a_flush, a_wr_en, a_rd_en;
    logic [7:0] a_wr_data, a_rd_data;
    logic [3:0] a_wr_index, a_rd_index;
    logic [4:0] a_count;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

    // Instance B: FWFT, 16 entries
    logic       b_flush, b_wr_en, b_rd_en;
    logic [7:0] b_wr_data, b_rd_data;
    logic [3:0] b_wr_index, b_rd_index;
    logic [4:0] b_count;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    // Instance C: standard read, 12 entries
    logic       c_flush, c_wr_en, c_rd_en;
    logic [7:0] c_wr_data, c_rd_data;
    logic [3:0] c_wr_index, c_rd_index;
    logic [3:0] c_count;
    logic       c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;

    syn_fifo_fwft #(.FIFO_ENTRIES(16), .DATA_WIDTH(8), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_a (
        .sys_clk(clk), .sys_rst(rst), .flush(a_flush),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_index(a_wr_index),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_index(a_rd_index),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    syn_fifo_fwft #(.FIFO_ENTRIES(16), .DATA_WIDTH(8), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_b (
        .sys_clk(clk), .sys_rst(rst), .flush(b_flush),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_index(b_wr_index),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_index(b_rd_index),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    syn_fifo_fwft #(.FIFO_ENTRIES(12), .DATA_WIDTH(8), .FWFT(0), .AFULL_THRESH(10), .AEMPTY_THRESH(2)) u_c (
        .sys_clk(clk), .sys_rst(rst), .flush(c_flush),
        .wr_en(c_wr_en), .wr_data(c_wr_data), .wr_index(c_wr_index),
        .rd_en(c_rd_en), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_index(c_rd_index),
        .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .count(c_count), .overflow(c_ovf), .underflow(c_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_w [16];
    logic [7:0] q [$];
    logic [7:0] head;
    logic [7:0] cval;

    initial begin
        rst = 1'b1;
        {a_flush, a_wr_en, a_rd_en} = '0; a_wr_data = '0;
        {b_flush, b_wr_en, b_rd_en} = '0; b_wr_data = '0;
        {c_flush, c_wr_en, c_rd_en} = '0; c_wr_data = '0;

        // Reset state, checked before the first clock edge
        #2;
        check("rst_count",    a_count,    0);
        check("rst_empty",    a_empty,    1);
        check("rst_aempty",   a_ae,       1);
        check("rst_full",     a_full,     0);
        check("rst_afull",    a_af,       0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_rd_data",  a_rd_data,  0);
        check("rst_wr_index", a_wr_index, 0);
        check("rst_rd_index", a_rd_index, 0);
        check("rst_ovf",      a_ovf,      0);
        check("rst_unf",      a_unf,      0);
        check("rst_b_valid",  b_rd_valid, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Test 1: fill 16 words
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = 8'($urandom_range(0, 255));
            check("t1_wr_index", a_wr_index, i);
            a_wr_en = 1'b1; a_wr_data = exp_w[i];
            tick();
            a_wr_en = 1'b0;
            check("t1_count",  a_count, i + 1);
            check("t1_afull",  a_af,    (i + 1) >= 14);
            check("t1_aempty", a_ae,    (i + 1) <= 2);
            check("t1_full",   a_full,  (i + 1) == 16);
            check("t1_empty",  a_empty, 0);
        end
        a_wr_en = 1'b1; a_wr_data = ~exp_w[0];
        tick();
        a_wr_en = 1'b0;
        check("t1_ovf",       a_ovf,      1);
        check("t1_ovf_count", a_count,    16);
        check("t1_ovf_wridx", a_wr_index, 0);
        check("t1_ovf_unf",   a_unf,      0);

        // Test 2: drain in write order, then underflow
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1;
            tick();
            check("t2_rd_valid", a_rd_valid, 1);
            check("t2_rd_data",  a_rd_data,  exp_w[i]);
            check("t2_count",    a_count,    15 - i);
        end
        a_rd_en = 1'b0;
        tick();
        check("t2_valid_low", a_rd_valid, 0);
        check("t2_empty",     a_empty,    1);
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        check("t2_unf",        a_unf,      1);
        check("t2_unf_valid",  a_rd_valid, 0);
        check("t2_unf_hold",   a_rd_data,  exp_w[15]);
        check("t2_unf_count",  a_count,    0);
        check("t2_ovf_sticky", a_ovf,      1);

        // Test 3: preload 5, then 48 cycles of simultaneous write and read
        for (int k = 0; k < 5; k++) begin
            a_wr_en = 1'b1; a_wr_data = 8'h10 + 8'(k);
            q.push_back(a_wr_data);
            tick();
        end
        a_wr_en = 1'b0;
        check("t3_preload", a_count, 5);
        for (int c = 0; c < 48; c++) begin
            a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'h40 + 8'(c);
            q.push_back(a_wr_data);
            tick();
            head = q.pop_front();
            check("t3_count", a_count, 5);
            check("t3_flags", {a_full, a_empty, a_af, a_ae}, 4'b0000);
            check("t3_data",  {a_rd_valid, a_rd_data}, {1'b1, head});
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        tick();
        check("t3_wr_index", a_wr_index, 5);
        check("t3_rd_index", a_rd_index, 0);

        // Test 5: reach count 9 with sticky flags set, then flush with concurrent requests
        for (int k = 0; k < 4; k++) begin
            a_wr_en = 1'b1; a_wr_data = 8'hC0 + 8'(k);
            tick();
        end
        a_wr_en = 1'b0;
        check("t5_count9", a_count, 9);
        check("t5_ovf_pre", a_ovf, 1);
        a_flush = 1'b1; a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'hFF;
        tick();
        a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        check("t5_fl_count", a_count,    0);
        check("t5_fl_empty", a_empty,    1);
        check("t5_fl_ovf",   a_ovf,      0);
        check("t5_fl_unf",   a_unf,      0);
        check("t5_fl_wridx", a_wr_index, 0);
        check("t5_fl_rdidx", a_rd_index, 0);
        check("t5_fl_valid", a_rd_valid, 0);

        // Test 4: FWFT visibility and pop
        b_wr_en = 1'b1; b_wr_data = 8'hA5;
        tick();
        b_wr_en = 1'b0;
        check("t4_valid", b_rd_valid, 1);
        check("t4_data",  b_rd_data,  8'hA5);
        check("t4_empty", b_empty,    0);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        check("t4_pop_valid", b_rd_valid, 0);
        check("t4_pop_empty", b_empty,    1);
        b_wr_en = 1'b1; b_wr_data = 8'h3C;
        tick();
        b_wr_data = 8'h5A;
        tick();
        b_wr_en = 1'b0;
        check("t4_head1",  b_rd_data, 8'h3C);
        check("t4_count2", b_count,   2);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        check("t4_head2", {b_rd_valid, b_rd_data}, {1'b1, 8'h5A});

        // Test 6: 12-entry instance, 30 write/read pairs
        for (int k = 0; k < 30; k++) begin
            cval = 8'((k * 9 + 3) & 8'hFF);
            check("t6_wr_index", c_wr_index, k % 12);
            c_wr_en = 1'b1; c_wr_data = cval;
            tick();
            c_wr_en = 1'b0;
            check("t6_rd_index", c_rd_index, k % 12);
            c_rd_en = 1'b1;
            tick();
            c_rd_en = 1'b0;
            check("t6_data",  {c_rd_valid, c_rd_data}, {1'b1, cval});
            check("t6_count", c_count, 0);
        end

        // Test 5b: underflow set, burst of 9 writes, reset asserted mid-burst
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        check("t5b_unf", a_unf, 1);
        for (int k = 0; k < 9; k++) begin
            a_wr_en = 1'b1; a_wr_data = 8'h70 + 8'(k);
            tick();
        end
        check("t5b_count9", a_count, 9);
        a_wr_data = 8'h99;
        #2 rst = 1'b1;
        #1;
        check("t5b_async_count", a_count,    0);
        check("t5b_async_empty", a_empty,    1);
        check("t5b_async_unf",   a_unf,      0);
        check("t5b_async_wridx", a_wr_index, 0);
        tick();
        a_wr_en = 1'b0;
        rst = 1'b0;
        tick();
        check("t5b_post_count", a_count,    0);
        check("t5b_post_empty", a_empty,    1);
        check("t5b_post_rdidx", a_rd_index, 0);
        check("t5b_post_valid", a_rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
